// File: rtl/timekeeper_if.sv
// Button and time/edit display signals of the timekeeper.
// The driver (bench or menu controller) uses master; timekeeper uses slave.
interface timekeeper_if;
    logic       mode;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       enter;
    logic       esc;
    logic [6:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
    logic       tick;
    logic       editing;
    logic       field;
    logic [6:0] edit_hour;
    logic [6:0] edit_min;

    modport master (
        output mode, up, down, left, right, enter, esc,
        input  hour, min, sec, tick, editing, field, edit_hour, edit_min
    );
    modport slave (
        input  mode, up, down, left, right, enter, esc,
        output hour, min, sec, tick, editing, field, edit_hour, edit_min
    );
endinterface

// File: rtl/timekeeper.sv
// 24h wall clock with a prescaled seconds tick and a button-driven HH:MM editor.
// Live time keeps running while editing; a commit reloads hh:mm:00 and restarts the second.
module timekeeper #(
    parameter int TICK_DIV = 100000000
) (
    input logic          clk,
    input logic          rst_n,
    timekeeper_if.slave  tk
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic {RUN, EDIT} state_e;

    state_e          state_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [6:0]      hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [6:0]      eh_q, em_q;
    logic            tick_q, tick_d, field_q;
    logic            wrap, commit, abort;

    assign wrap   = (presc_q == PW'(TICK_DIV - 1));
    assign abort  = !tk.mode || tk.esc;
    assign commit = (state_q == EDIT) && !abort && tk.enter;

    // Live-time next state; a commit overrides any advance from a same-cycle wrap.
    always_comb begin
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        presc_d = wrap ? '0 : presc_q + PW'(1);
        tick_d  = wrap && !commit;
        if (commit) begin
            hour_d  = eh_q;
            min_d   = em_q;
            sec_d   = '0;
            presc_d = '0;
        end else if (wrap) begin
            if (sec_q == 7'd59) begin
                sec_d = '0;
                if (min_q == 7'd59) begin
                    min_d  = '0;
                    hour_d = (hour_q == 7'd23) ? 7'd0 : hour_q + 7'd1;
                end else begin
                    min_d = min_q + 7'd1;
                end
            end else begin
                sec_d = sec_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            presc_q <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            tick_q  <= 1'b0;
            field_q <= 1'b0;
            eh_q    <= '0;
            em_q    <= '0;
        end else begin
            presc_q <= presc_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
            case (state_q)
                RUN: begin
                    if (tk.enter && tk.mode) begin
                        state_q <= EDIT;
                        eh_q    <= hour_q;
                        em_q    <= min_q;
                        field_q <= 1'b0;
                    end
                end
                EDIT: begin
                    if (abort || tk.enter) begin
                        state_q <= RUN;
                        field_q <= 1'b0;
                    end else if (tk.up != tk.down) begin
                        if (!field_q) begin
                            if (tk.up) eh_q <= (eh_q == 7'd23) ? 7'd0  : eh_q + 7'd1;
                            else       eh_q <= (eh_q == 7'd0)  ? 7'd23 : eh_q - 7'd1;
                        end else begin
                            if (tk.up) em_q <= (em_q == 7'd59) ? 7'd0  : em_q + 7'd1;
                            else       em_q <= (em_q == 7'd0)  ? 7'd59 : em_q - 7'd1;
                        end
                    end else if (tk.left != tk.right) begin
                        field_q <= !field_q;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign tk.hour      = hour_q;
    assign tk.min       = min_q;
    assign tk.sec       = sec_q;
    assign tk.tick      = tick_q;
    assign tk.editing   = (state_q == EDIT);
    assign tk.field     = field_q;
    assign tk.edit_hour = eh_q;
    assign tk.edit_min  = em_q;
endmodule

// File: tb/tb_timekeeper.sv
// Directed test of timekeeper with TICK_DIV=4: reset, counting, editing, commit/wrap race, day wrap.
module tb_timekeeper;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] btn = '0;   // {esc, enter, right, left, down, up}
    int         n_chk = 0;
    int         n_err = 0;
    int         ticks;

    localparam logic [5:0] UP = 6'b000001, DN = 6'b000010, LT = 6'b000100,
                           RT = 6'b001000, EN = 6'b010000, ES = 6'b100000;

    timekeeper_if tk_if();
    assign tk_if.up    = btn[0];
    assign tk_if.down  = btn[1];
    assign tk_if.left  = btn[2];
    assign tk_if.right = btn[3];
    assign tk_if.enter = btn[4];
    assign tk_if.esc   = btn[5];

    timekeeper #(.TICK_DIV(4)) dut (.clk(clk), .rst_n(rst_n), .tk(tk_if));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [5:0] b, input int n = 1);
        for (int i = 0; i < n; i++) begin
            btn = b;
            step();
            btn = '0;
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".hour"}, tk_if.hour, h);
        chk({tag, ".min"},  tk_if.min,  m);
        chk({tag, ".sec"},  tk_if.sec,  s);
    endtask

    task automatic chk_zero(input string tag);
        chk_time(tag, 0, 0, 0);
        chk({tag, ".tick"},  tk_if.tick, 0);
        chk({tag, ".edit"},  tk_if.editing, 0);
        chk({tag, ".field"}, tk_if.field, 0);
        chk({tag, ".eh"},    tk_if.edit_hour, 0);
        chk({tag, ".em"},    tk_if.edit_min, 0);
    endtask

    initial begin
        tk_if.mode = 1'b1;
        btn = EN | UP;                    // buttons must be ignored under reset
        step(2);
        btn = '0;
        chk_zero("reset");

        rst_n = 1'b1;
        step(3);
        chk("first_tick_pre", tk_if.tick, 0);
        step();
        chk("first_tick", tk_if.tick, 1);
        chk("first_sec", tk_if.sec, 1);
        step();
        chk("tick_one_cycle", tk_if.tick, 0);
        ticks = 0;
        for (int i = 0; i < 39; i++) begin
            step();
            ticks += tk_if.tick;
        end
        chk("tick_count", ticks, 10);
        chk("sec_count", tk_if.sec, 11);

        // Load 15:39 and run to 15:39:45
        press(EN);
        chk("edit_enter", tk_if.editing, 1);
        press(UP, 15);
        press(RT);
        press(UP, 39);
        press(EN);
        chk_time("commit1", 15, 39, 0);
        chk("commit1.edit", tk_if.editing, 0);
        step(180);
        chk_time("run45", 15, 39, 45);

        press(EN);
        chk("e2.edit", tk_if.editing, 1);
        chk("e2.eh", tk_if.edit_hour, 15);
        chk("e2.em", tk_if.edit_min, 39);
        chk("e2.field", tk_if.field, 0);
        press(UP, 2);
        chk("e2.up2", tk_if.edit_hour, 17);
        press(ES);
        chk("esc.edit", tk_if.editing, 0);
        chk_time("esc", 15, 39, 46);
        press(UP);
        chk("run_hold_eh", tk_if.edit_hour, 17);
        chk("run_field0", tk_if.field, 0);

        // Buffer wraps and dual-button no-ops
        press(EN);
        press(UP, 9);
        chk("eh_wrap_up", tk_if.edit_hour, 0);
        press(DN);
        chk("eh_wrap_dn", tk_if.edit_hour, 23);
        press(UP | DN);
        chk("up_dn_noop", tk_if.edit_hour, 23);
        press(RT);
        chk("field_min", tk_if.field, 1);
        press(LT | RT);
        chk("lt_rt_noop", tk_if.field, 1);
        press(UP, 20);
        chk("em_59", tk_if.edit_min, 59);
        press(UP);
        chk("em_wrap_up", tk_if.edit_min, 0);
        press(EN);
        chk_time("commit2", 23, 0, 0);
        chk("commit2.tick", tk_if.tick, 0);
        step(3);
        chk("commit2.pre", tk_if.tick, 0);
        step();
        chk("commit2.tick4", tk_if.tick, 1);
        chk("commit2.sec", tk_if.sec, 1);

        // Commit lands on the prescaler wrap
        press(EN);                        // presc 1
        step(2);                          // presc 3
        press(EN);
        chk("race.tick", tk_if.tick, 0);
        chk_time("race", 23, 0, 0);
        step(3);
        chk("race.sec_hold", tk_if.sec, 0);
        step();
        chk("race.tick4", tk_if.tick, 1);
        chk("race.sec1", tk_if.sec, 1);

        // 23:59 then run through midnight
        press(EN);
        press(RT);
        press(DN);
        chk("em_wrap_dn", tk_if.edit_min, 59);
        press(EN);
        chk_time("commit3", 23, 59, 0);
        step(236);
        chk_time("pre_midnight", 23, 59, 59);
        step(4);
        chk_time("midnight", 0, 0, 0);
        chk("midnight.tick", tk_if.tick, 1);

        // Mode drop aborts; enter ignored without mode
        press(EN);
        press(UP);
        chk("m0.eh", tk_if.edit_hour, 1);
        tk_if.mode = 1'b0;
        step();
        chk("m0.abort", tk_if.editing, 0);
        chk("m0.hour", tk_if.hour, 0);
        press(EN);
        chk("m0.enter", tk_if.editing, 0);

        // Reset mid-edit with a button pulse
        tk_if.mode = 1'b1;
        press(EN);
        chk("rst.pre", tk_if.editing, 1);
        btn = UP;
        rst_n = 1'b0;
        step();
        btn = '0;
        chk_zero("rst_edit");
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/timekeeper.md
TIMEKEEPER -- requirements
Module: timekeeper

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per second (minimum 2).
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port mode  in  1  1 = this block owns the buttons; 0 = buttons ignored.
REQ-005 SHALL have ports up, down, left, right, enter, esc  in  1 each  debounced single-cycle button pulses.
REQ-006 SHALL have ports hour, min, sec  out  7 each  live time in binary (0-23, 0-59, 0-59); these feed the alarm comparator.
REQ-007 SHALL have port tick  out  1  one-cycle pulse on each second advance.
REQ-008 SHALL have port editing  out  1  high while in state EDIT.
REQ-009 SHALL have port field  out  1  edit cursor: 0 = hour, 1 = minute.
REQ-010 SHALL have ports edit_hour, edit_min  out  7 each  edit buffer contents for the display.

Function
REQ-011 SHALL run a prescaler from 0 to TICK_DIV-1; at TICK_DIV-1 it wraps to 0, pulses tick and advances sec.
REQ-012 SHALL advance time with carries: sec 59->0 increments min; min 59->0 increments hour; hour 23->0; 23:59:59 -> 00:00:00 in one tick.
REQ-013 SHALL keep hour, min, sec counting in both states; editing never freezes live time.
REQ-014 SHALL implement FSM states RUN and EDIT.
REQ-015 RUN: enter && mode -> EDIT next cycle; edit_hour/edit_min <= current hour/min; field <= 0.
REQ-016 RUN: all other buttons have no effect.
REQ-017 EDIT priority, one action per cycle: (!mode or esc) > enter > up/down > left/right.
REQ-018 EDIT: !mode or esc discards the buffer and returns to RUN; time is unchanged.
REQ-019 EDIT: enter commits (hour <= edit_hour, min <= edit_min, sec <= 0, prescaler <= 0) and returns to RUN.
REQ-020 EDIT: up increments the selected buffer field with wrap (hour 23->0, min 59->0); down decrements with wrap (0->23, 0->59).
REQ-021 EDIT: up and down together produce no change.
REQ-022 EDIT: left or right toggles field; both together produce no change.
REQ-023 Commit in the same cycle as a prescaler wrap: commit wins, tick stays 0 that cycle, and no second advance is applied.
REQ-024 SHALL register all outputs; tick is high for exactly one cycle per wrap.
REQ-025 In RUN, edit_hour/edit_min SHALL hold their last values; field SHALL hold 0.

Reset
REQ-026 rst_n low at a clk edge SHALL force hour=min=sec=0, prescaler=0, tick=0, state RUN, editing=0, field=0, edit_hour=edit_min=0.
REQ-027 Reset during EDIT SHALL discard the buffer; there is no commit.
REQ-028 Reset SHALL dominate every button and the tick in the same cycle.

Verification (TICK_DIV=4)
REQ-029 Release reset, run 4*86400 cycles -> tick every 4th cycle; wraps through 23:59:59 to 00:00:00.
REQ-030 At 15:39:45, mode=1, pulse enter -> editing=1, edit_hour=15, edit_min=39; then up, up -> edit_hour=17; pulse esc -> editing=0, live time unaffected.
REQ-031 In EDIT with edit_hour=0, pulse down -> 23; pulse right, set edit_min=59, pulse up -> 0; pulse enter -> hour=23, min=0, sec=0, next tick 4 cycles later.
REQ-032 Pulse enter in the cycle the prescaler is at 3 -> sec=0 after commit, tick=0 that cycle.
REQ-033 Drop mode to 0 during EDIT -> returns to RUN with no commit; with mode=0, enter has no effect.
REQ-034 Assert rst_n=0 mid-EDIT with up pulsed the same cycle -> all outputs zero, state RUN.
